// File: rtl/mmu_mem_arbiter.sv
// mmu_mem_arbiter: shares one translation path and one memory bus between IF and DM requesters.
// Optional TLB handshake for mapped segments is enabled by defining MMU_ARB_TLB_EN.
module mmu_mem_arbiter #(
   parameter int STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        user_mode,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic [31:0] if_rdata,
   output logic        if_ready,
   output logic [1:0]  if_excp,
   input  logic        dm_req,
   input  logic        dm_we,
   input  logic [3:0]  dm_be,
   input  logic [31:0] dm_addr,
   input  logic [31:0] dm_wdata,
   output logic [31:0] dm_rdata,
   output logic        dm_ready,
   output logic [1:0]  dm_excp,
   output logic        tlb_lookup,
   output logic [31:0] tlb_vaddr,
   input  logic        tlb_done,
   input  logic        tlb_hit,
   input  logic        tlb_uncached,
   input  logic [31:0] tlb_paddr,
   output logic        bus_req,
   output logic        bus_we,
   output logic [3:0]  bus_be,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_wdata,
   output logic        bus_uncached,
   input  logic        bus_ack,
   input  logic [31:0] bus_rdata
);
   localparam int SW = $clog2(STARVE_LIMIT + 1);
   typedef enum logic [1:0] {IDLE, LOOKUP, BUS, RESP} state_t;
   state_t      state_q, state_d;
   logic        dm_own_q, dm_own_d;
   logic        we_q, we_d;
   logic [3:0]  be_q, be_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] paddr_q, paddr_d;
   logic        unc_q, unc_d;
   logic [1:0]  excp_q, excp_d;
   logic [SW-1:0] starve_q, starve_d;
   logic [31:0] if_rdata_q, if_rdata_d, dm_rdata_q, dm_rdata_d;
   logic        grant_if;
   logic [31:0] req_addr;
   assign grant_if = if_req && (!dm_req || starve_q == SW'(STARVE_LIMIT));
   assign req_addr = grant_if ? if_addr : dm_addr;
`ifndef MMU_ARB_TLB_EN
   logic unused_tlb;
   assign unused_tlb = ^{tlb_done, tlb_hit, tlb_uncached, tlb_paddr};
`endif
   // State and datapath registers; reset aborts any access in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         dm_own_q   <= 1'b0;
         we_q       <= 1'b0;
         be_q       <= 4'h0;
         wdata_q    <= 32'h0;
         paddr_q    <= 32'h0;
         unc_q      <= 1'b0;
         excp_q     <= 2'b00;
         starve_q   <= '0;
         if_rdata_q <= 32'h0;
         dm_rdata_q <= 32'h0;
      end else begin
         state_q    <= state_d;
         dm_own_q   <= dm_own_d;
         we_q       <= we_d;
         be_q       <= be_d;
         wdata_q    <= wdata_d;
         paddr_q    <= paddr_d;
         unc_q      <= unc_d;
         excp_q     <= excp_d;
         starve_q   <= starve_d;
         if_rdata_q <= if_rdata_d;
         dm_rdata_q <= dm_rdata_d;
      end
   end
   // Arbitration, segment decode, handshakes and starvation counting.
   always_comb begin
      state_d    = state_q;
      dm_own_d   = dm_own_q;
      we_d       = we_q;
      be_d       = be_q;
      wdata_d    = wdata_q;
      paddr_d    = paddr_q;
      unc_d      = unc_q;
      excp_d     = excp_q;
      if_rdata_d = if_rdata_q;
      dm_rdata_d = dm_rdata_q;
      starve_d   = starve_q;
      if (!if_req) starve_d = '0;
      else if (state_q == IDLE && dm_req)
         starve_d = grant_if ? '0 : (starve_q == SW'(STARVE_LIMIT) ? starve_q : starve_q + SW'(1));
      else if (state_q == IDLE) starve_d = '0;
      case (state_q)
         IDLE: if (if_req || dm_req) begin
            dm_own_d = !grant_if;
            we_d     = !grant_if && dm_we;
            be_d     = grant_if ? 4'hF : dm_be;
            wdata_d  = grant_if ? 32'h0 : dm_wdata;
            excp_d   = 2'b00;
            if (user_mode && req_addr[31]) begin
               excp_d  = 2'b01;
               state_d = RESP;
            end else if (req_addr[31:30] == 2'b10) begin
               paddr_d = {3'b000, req_addr[28:0]};
               unc_d   = req_addr[29];
               state_d = BUS;
            end else begin
               paddr_d = req_addr;
               unc_d   = 1'b0;
`ifdef MMU_ARB_TLB_EN
               state_d = LOOKUP;
`else
               state_d = BUS;
`endif
            end
         end
`ifdef MMU_ARB_TLB_EN
         LOOKUP: if (tlb_done) begin
            paddr_d = tlb_hit ? tlb_paddr : paddr_q;
            unc_d   = tlb_hit && tlb_uncached;
            excp_d  = tlb_hit ? 2'b00 : 2'b10;
            state_d = tlb_hit ? BUS : RESP;
         end
`endif
         BUS: if (bus_ack) begin
            if (!we_q && dm_own_q) dm_rdata_d = bus_rdata;
            if (!we_q && !dm_own_q) if_rdata_d = bus_rdata;
            state_d = RESP;
         end
         default: state_d = IDLE;
      endcase
   end
   assign bus_req      = state_q == BUS;
   assign bus_we       = bus_req && we_q;
   assign bus_be       = bus_req ? be_q : 4'h0;
   assign bus_addr     = bus_req ? paddr_q : 32'h0;
   assign bus_wdata    = bus_req ? wdata_q : 32'h0;
   assign bus_uncached = bus_req && unc_q;
`ifdef MMU_ARB_TLB_EN
   assign tlb_lookup   = state_q == LOOKUP;
   assign tlb_vaddr    = tlb_lookup ? paddr_q : 32'h0;
`else
   assign tlb_lookup   = 1'b0;
   assign tlb_vaddr    = 32'h0;
`endif
   assign if_ready     = state_q == RESP && !dm_own_q;
   assign dm_ready     = state_q == RESP && dm_own_q;
   assign if_excp      = if_ready ? excp_q : 2'b00;
   assign dm_excp      = dm_ready ? excp_q : 2'b00;
   assign if_rdata     = if_rdata_q;
   assign dm_rdata     = dm_rdata_q;
endmodule

// File: doc/mmu_mem_arbiter.md
# mmu_mem_arbiter

Sequential controller that shares one address-translation path and one external memory bus between the instruction-fetch (IF) and data-memory (DM) requesters of the CPU. It grants one requester at a time and classifies the virtual address by segment: kseg0/kseg1 are mapped directly, and useg/kseg2/kseg3 go through a TLB lookup handshake. It checks user-mode privilege, runs the bus transaction and returns data or an exception code. It sits between the pipeline's IF/MEM stages and the bus/TLB blocks.

## Interface
Parameters:
- STARVE_LIMIT, 4: maximum consecutive DM grants while if_req is pending, after which IF is granted.

Ports (reset is synchronous and active-high; one clock):
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous active-high reset
- user_mode  in  1  CPU in user mode, sampled at grant
- if_req  in  1  IF access request, held until if_ready
- if_addr  in  32  IF virtual address, stable while if_req
- if_rdata  out  32  fetched word, valid with if_ready
- if_ready  out  1  one-cycle completion pulse
- if_excp  out  2  00 none, 01 address error, 10 TLB miss; valid with if_ready
- dm_req, dm_we  in  1 each  DM request / write
- dm_be  in  4  byte enables
- dm_addr, dm_wdata  in  32 each  DM virtual address / write data
- dm_rdata  out  32; dm_ready  out  1; dm_excp  out  2  same semantics as IF
- tlb_lookup  out  1  TLB lookup strobe, held until tlb_done
- tlb_vaddr  out  32  address under lookup
- tlb_done, tlb_hit, tlb_uncached  in  1 each  lookup result
- tlb_paddr  in  32  translated address
- bus_req, bus_we  out  1 each; bus_be  out  4; bus_addr, bus_wdata  out  32; bus_uncached  out  1
- bus_ack  in  1  transaction complete; bus_rdata  in  32

## Operation
- States: IDLE, LOOKUP, BUS, RESP.
- IDLE: arbitrate. DM wins, unless starve_cnt == STARVE_LIMIT and if_req = 1, in which case IF wins. Latch the owner, address, we, be and wdata. IF is always a read with be = 4'hF.
- Privilege: if user_mode = 1 and addr[31] = 1, go to RESP with excp = 01; no bus or TLB activity.
- addr[31:29] = 100 or 101: physical address = {3'b0, addr[28:0]} -> BUS. bus_uncached = 1 only for 101.
- Other segments -> LOOKUP: tlb_lookup = 1 until tlb_done. On a hit, use tlb_paddr and tlb_uncached and go to BUS. On a miss, go to RESP with excp = 10.
- BUS: bus_req = 1 with stable outputs until bus_ack. On bus_ack, capture bus_rdata (reads) and go to RESP.
- RESP: the owner's ready = 1 for exactly one cycle, along with rdata and excp. Return to IDLE.
- starve_cnt (width clog2(STARVE_LIMIT+1)): increments on a DM grant while if_req = 1, saturating. Clears on an IF grant or when if_req = 0.
- An idle requester's rdata holds its last value. excp = 00 except in the RESP cycle.

## Timing
- Reset: state = IDLE, starve_cnt = 0, and every output 0 (ready, excp, rdata, bus_*, tlb_*).
- Grant sampled at edge N. Unmapped segment: bus_req high from cycle N+1. Mapped segment: tlb_lookup high from N+1.
- bus_ack in cycle M -> ready in cycle M+1. Minimum unmapped latency: req in cycle N, ack in N+1, ready in N+2.
- Address error: ready in cycle N+1.
- Back-to-back: a requester may keep req high through ready and present a new address in the cycle after ready. That request is arbitrated in IDLE (one dead cycle minimum).
- Simultaneous if_req/dm_req in IDLE: DM is granted unless the starvation threshold is reached. The loser keeps waiting; no request is ever dropped.
- Reset mid-operation: bus_req and tlb_lookup are low from the next cycle. A bus_ack or tlb_done arriving afterwards is ignored. No ready is issued for the aborted access.
- bus_ack or tlb_done outside BUS/LOOKUP respectively: ignored.

## Configuration
- MMU_ARB_TLB_EN defined: mapped segments use the LOOKUP/TLB handshake as above.
- MMU_ARB_TLB_EN undefined:
  - The LOOKUP state and TLB ports are not used: tlb_lookup and tlb_vaddr are tied 0, and tlb_* inputs are ignored.
  - Mapped segments pass through as identity (physical address = virtual address) with bus_uncached = 0, going directly to BUS.
  - TLB miss exception code 10 is never produced.

## Test plan
- dm_req read at 0x8000_0010, kernel mode, bus_ack one cycle after bus_req -> bus_addr 0x0000_0010, bus_uncached 0, dm_ready two cycles after bus_req rises, dm_rdata = bus_rdata, dm_excp 00.
- if_req at 0xA000_0100 -> bus_addr 0x0000_0100, bus_uncached 1, if_ready with fetched word.
- user_mode = 1, dm_req at 0x8000_0000 -> dm_ready the next cycle with dm_excp 01, bus_req and tlb_lookup never asserted.
- if_req at 0x0040_0000 (TLB enabled): tlb_hit with tlb_paddr 0x0123_4000 -> bus_addr 0x0123_4000. A second access with tlb_hit = 0 -> if_excp 10, no bus_req.
- if_req and dm_req held continuously, STARVE_LIMIT = 4, DM re-requesting back-to-back -> grant order DM×4, IF, DM×4, IF...
- rst asserted while bus_req is high, bus_ack arrives afterwards -> all outputs 0 from the next cycle, no ready pulse, next request serviced normally.
